imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Arbitrates the single port of the 64×16 instruction memory between two requesters: the CPU fetch path (read-only) and the program loader (write-only boot/download path). Owns the memory's read/write select (1 = write, 0 = read), address and write data. Sits between the PC/fetch logic, the loader, and the instruction memory. Sustains one transfer per cycle to the current owner, with an optional anti-starvation guard for fetch.

## Interface
Parameters:
- DEPTH, 64, number of 16-bit instruction words; valid addresses 0..DEPTH-1
- LOAD_MAX, 8, max consecutive load transfers while fetch waits (fair mode only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_req  in  1  fetch request; held with fetch_addr until granted
- fetch_addr  in  16  word address to read
- fetch_gnt  out  1  fetch transfer occurs this cycle
- fetch_valid  out  1  fetch_data valid (registered, one-cycle pulse per transfer)
- fetch_data  out  16  instruction read
- fetch_err  out  1  with fetch_valid: address was out of range
- load_req  in  1  load request; held with load_addr/load_data until granted
- load_addr  in  16  word address to write
- load_data  in  16  instruction to write
- load_gnt  out  1  load transfer occurs this cycle
- load_err  out  1  registered pulse: previous load transfer was out of range, write suppressed
- load_count  out  7  successful writes since reset, saturates at 127
- cpu_hold  out  1  stall request to the CPU: load_req or owner == LOAD
- mem_rw  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, combinational from mem_addr

## Operation
- Owner FSM states: IDLE, FETCH, LOAD. Reset state IDLE.
- A transfer occurs in any cycle where the requester's req is high and its state owns the port. Grant is combinational: fetch_gnt = fetch_req & (state == FETCH); load_gnt likewise.
- Memory drive:
  - FETCH: mem_addr = fetch_addr, mem_rw = 0.
  - LOAD: mem_addr = load_addr, mem_wdata = load_data, mem_rw = load_gnt & in-range.
  - IDLE: mem_rw = 0, mem_addr = 0, mem_wdata = 0.
- Next state, evaluated every cycle:
  - IDLE: load_req → LOAD; else fetch_req → FETCH; else IDLE.
  - FETCH: load_req → LOAD (the fetch transfer this cycle still completes); else fetch_req → FETCH; else IDLE.
  - LOAD: if load_req and not fair-trip → LOAD; else if fetch_req → FETCH; else if load_req → LOAD; else IDLE.
- Fetch read: fetch_data is registered from mem_rdata on a fetch transfer. If fetch_addr ≥ DEPTH, fetch_data = 16'h0000 and fetch_err = 1.
- Load write: if load_addr ≥ DEPTH, the write is suppressed (mem_rw held at 0), but load_gnt still pulses so the loader advances, and load_err pulses on the next cycle. load_count increments only on in-range writes.
- Requesters present the next address/data on the cycle after a grant, or drop req.

## Timing
- Switching owner from IDLE or the other owner costs one bubble cycle.
- Back-to-back transfers by the same owner: one per cycle.
- Fetch latency: fetch_valid is asserted one cycle after fetch_gnt.
- Reset values: state IDLE; fetch_valid, fetch_err, load_err, fetch_data, load_count = 0. Combinational outputs then follow from IDLE (all 0 unless load_req drives cpu_hold).
- Reset mid-write: mem_rw drops immediately (asynchronous). A fetch_valid pending from the cycle before reset is discarded.
- Simultaneous req in IDLE: load wins.
- load_count at 127: holds at 127.

## Configuration
- IMEM_ARB_FAIR_EN defined: a starve counter counts consecutive load transfers while fetch_req is high.
  - When it reaches LOAD_MAX, fair-trip is asserted and the next state is FETCH, guaranteeing at least one fetch transfer.
  - The counter clears on any fetch transfer, or when fetch_req is low.
- IMEM_ARB_FAIR_EN undefined: fair-trip is constant 0, giving strict load priority. Fetch starves while load_req stays high. LOAD_MAX is unused.

## Structure
- Shared package imem_pkg: DEPTH default, state enum (ARB_IDLE, ARB_FETCH, ARB_LOAD), NOP word 16'h0000, RW_READ/RW_WRITE constants.
- One sub-module: imem_starve_cnt, the saturating LOAD_MAX counter with clear and trip output. It is instantiated only under IMEM_ARB_FAIR_EN.

## Test plan
- Reset, then a single fetch_req with addr 5 (mem[5]=16'hA3C1) → fetch_gnt in cycle 2, fetch_valid with data A3C1 in cycle 3, fetch_err = 0.
- Load burst of addrs 0..3 with load_req held → one bubble, then 4 consecutive load_gnt with mem_rw = 1; load_count = 4; cpu_hold high throughout.
- Fetch and load requested together from IDLE → LOAD granted first. With fair mode on, LOAD_MAX = 8 and a 20-word load, one fetch is interleaved after the 8th write.
- load_addr = 70 → load_gnt pulses, mem_rw stays 0, load_err pulses next cycle, load_count unchanged. fetch_addr = 64 → fetch_data 0000, fetch_err = 1.
- rst asserted mid-burst during a write cycle → mem_rw low immediately, all registered outputs 0, state IDLE, and no fetch_valid after release.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and owner encoding for the instruction-memory port arbiter.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 64;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CNT_W      = 7;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0000;
  localparam logic              RW_READ  = 1'b0;
  localparam logic              RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_LOAD  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/imem_starve_cnt.sv
// Counts consecutive load transfers while fetch waits; trip_c fires on the
// transfer that reaches LOAD_MAX so the owner hands over right after it.
module imem_starve_cnt #(
  parameter int unsigned LOAD_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic trip_c
);

  localparam int unsigned CW = $clog2(LOAD_MAX + 1);

  logic [CW-1:0] cnt;

  assign trip_c = inc && ((32'(cnt) + 32'd1) >= LOAD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (32'(cnt) < LOAD_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory port between CPU fetch (read) and
// the program loader (write). Define IMEM_ARB_FAIR_EN to bound load bursts.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = IMEM_DEPTH,
  parameter int unsigned LOAD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  output logic              load_err,
  output logic [CNT_W-1:0]  load_count,
  output logic              cpu_hold,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if ((LOAD_MAX < 1) || (DEPTH < 1) || (DEPTH > 65536)) begin : g_param_chk
    $error("imem_port_arbiter: DEPTH must be 1..65536 and LOAD_MAX >= 1");
  end

  arb_state_e state;
  logic       fetch_in_range;
  logic       load_in_range;
  logic       fair_trip;

  assign fetch_in_range = 32'(fetch_addr) < DEPTH;
  assign load_in_range  = 32'(load_addr) < DEPTH;

`ifdef IMEM_ARB_FAIR_EN
  imem_starve_cnt #(
    .LOAD_MAX (LOAD_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (load_gnt & fetch_req),
    .clr    (fetch_gnt | ~fetch_req),
    .trip_c (fair_trip)
  );
`else
  assign fair_trip = 1'b0;
`endif

  // Grants and memory drive follow the current owner combinationally.
  always_comb begin
    fetch_gnt = fetch_req & (state == ARB_FETCH);
    load_gnt  = load_req & (state == ARB_LOAD);
    mem_rw    = RW_READ;
    mem_addr  = '0;
    mem_wdata = NOP_WORD;
    case (state)
      ARB_FETCH: mem_addr = fetch_addr;
      ARB_LOAD: begin
        mem_addr  = load_addr;
        mem_wdata = load_data;
        mem_rw    = (load_gnt && load_in_range) ? RW_WRITE : RW_READ;
      end
      default: ;
    endcase
  end

  assign cpu_hold = load_req | (state == ARB_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_LOAD: begin
          if (load_req && !fair_trip) state <= ARB_LOAD;
          else if (fetch_req)         state <= ARB_FETCH;
          else if (load_req)          state <= ARB_LOAD;
          else                        state <= ARB_IDLE;
        end
        // IDLE and FETCH share the load-first rule
        default: begin
          if (load_req)       state <= ARB_LOAD;
          else if (fetch_req) state <= ARB_FETCH;
          else                state <= ARB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= NOP_WORD;
      load_err    <= 1'b0;
      load_count  <= '0;
    end else begin
      fetch_valid <= fetch_gnt;
      fetch_err   <= fetch_gnt & ~fetch_in_range;
      if (fetch_gnt) begin
        fetch_data <= fetch_in_range ? mem_rdata : NOP_WORD;
      end
      load_err <= load_gnt & ~load_in_range;
      if (load_gnt && load_in_range && (load_count != CNT_MAX)) begin
        load_count <= load_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_imem_port_arbiter;

  localparam int DEPTH    = 64;
  localparam int LOAD_MAX = 8;
  localparam int OWN_IDLE = 0;
  localparam int OWN_F    = 1;
  localparam int OWN_L    = 2;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        fetch_err;
  logic        load_req;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load_gnt;
  logic        load_err;
  logic [6:0]  load_count;
  logic        cpu_hold;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  imem_port_arbiter #(
    .DEPTH    (DEPTH),
    .LOAD_MAX (LOAD_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .load_req    (load_req),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_gnt    (load_gnt),
    .load_err    (load_err),
    .load_count  (load_count),
    .cpu_hold    (cpu_hold),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int gap_pct  = 0;

  logic [15:0] fq[$];
  logic [15:0] lq_a[$];
  logic [15:0] lq_d[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] init_word(input int i);
    return (i == 5) ? 16'hA3C1 : 16'((i * 997 + 123) ^ 16'h5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory seen by the DUT; out-of-range reads return junk.
  logic [15:0] env_mem [0:DEPTH-1];
  assign mem_rdata = (mem_addr < 16'(DEPTH)) ? env_mem[mem_addr[5:0]] : 16'hBAD0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
    end else if (mem_rw && (mem_addr < 16'(DEPTH))) begin
      env_mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [15:0] ref_mem [0:DEPTH-1];
  int          m_owner, n_owner;
  logic        m_fvalid, n_fvalid, m_ferr, n_ferr, m_lerr, n_lerr;
  logic [15:0] m_fdata, n_fdata;
  int          m_count, n_count;
  logic        n_wr;
  logic [5:0]  n_wa;
  logic [15:0] n_wd;
  logic        e_fgnt, e_lgnt, e_rw, e_hold, fin, lin, trip;
  logic [15:0] e_addr, e_wdata;
`ifdef IMEM_ARB_FAIR_EN
  int          m_starve, n_starve;
`endif

  initial begin : model_update
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = OWN_IDLE; n_owner = OWN_IDLE;
        m_fvalid = 1'b0; n_fvalid = 1'b0; m_ferr = 1'b0; n_ferr = 1'b0;
        m_lerr = 1'b0; n_lerr = 1'b0; m_fdata = 16'h0; n_fdata = 16'h0;
        m_count = 0; n_count = 0; n_wr = 1'b0; n_wa = 6'd0; n_wd = 16'h0;
        e_fgnt = 1'b0; e_lgnt = 1'b0;
`ifdef IMEM_ARB_FAIR_EN
        m_starve = 0; n_starve = 0;
`endif
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      end else begin
        m_owner = n_owner; m_fvalid = n_fvalid; m_ferr = n_ferr; m_lerr = n_lerr;
        m_fdata = n_fdata; m_count = n_count;
        if (n_wr) ref_mem[n_wa] = n_wd;
`ifdef IMEM_ARB_FAIR_EN
        m_starve = n_starve;
`endif
      end
    end
  end

  initial begin : model_compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        fin     = int'(fetch_addr) < DEPTH;
        lin     = int'(load_addr) < DEPTH;
        e_fgnt  = fetch_req && (m_owner == OWN_F);
        e_lgnt  = load_req && (m_owner == OWN_L);
        e_rw    = e_lgnt && lin;
        e_addr  = (m_owner == OWN_F) ? fetch_addr : (m_owner == OWN_L) ? load_addr : 16'h0;
        e_wdata = (m_owner == OWN_L) ? load_data : 16'h0;
        e_hold  = load_req || (m_owner == OWN_L);
        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fgnt));
        chk("load_gnt", 32'(load_gnt), 32'(e_lgnt));
        chk("mem_rw", 32'(mem_rw), 32'(e_rw));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
        chk("fetch_valid", 32'(fetch_valid), 32'(m_fvalid));
        if (m_fvalid) begin
          chk("fetch_data", 32'(fetch_data), 32'(m_fdata));
          chk("fetch_err", 32'(fetch_err), 32'(m_ferr));
        end
        chk("load_err", 32'(load_err), 32'(m_lerr));
        chk("load_count", 32'(load_count), 32'(m_count));

        n_fvalid = e_fgnt;
        n_fdata  = m_fdata;
        n_ferr   = m_ferr;
        if (e_fgnt) begin
          n_fdata = fin ? ref_mem[fetch_addr[5:0]] : 16'h0;
          n_ferr  = !fin;
        end
        n_lerr  = e_lgnt && !lin;
        n_wr    = e_rw;
        n_wa    = load_addr[5:0];
        n_wd    = load_data;
        n_count = (e_rw && m_count < 127) ? m_count + 1 : m_count;
        trip    = 1'b0;
`ifdef IMEM_ARB_FAIR_EN
        if (e_lgnt && fetch_req) begin
          n_starve = m_starve + 1;
          trip     = n_starve >= LOAD_MAX;
        end else if (e_fgnt || !fetch_req) begin
          n_starve = 0;
        end else begin
          n_starve = m_starve;
        end
`endif
        if (m_owner == OWN_L)
          n_owner = (load_req && !trip) ? OWN_L : fetch_req ? OWN_F : load_req ? OWN_L : OWN_IDLE;
        else
          n_owner = load_req ? OWN_L : fetch_req ? OWN_F : OWN_IDLE;
      end
    end
  end

  // Requesters: hold each item until the model says it was granted.
  initial begin : driver
    logic f_act, l_act;
    f_act = 1'b0; l_act = 1'b0;
    fetch_req = 1'b0; fetch_addr = 16'h0;
    load_req = 1'b0; load_addr = 16'h0; load_data = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        f_act = 1'b0; l_act = 1'b0; fetch_req = 1'b0; load_req = 1'b0;
      end else begin
        if (f_act && e_fgnt) begin void'(fq.pop_front()); f_act = 1'b0; end
        if (l_act && e_lgnt) begin void'(lq_a.pop_front()); void'(lq_d.pop_front()); l_act = 1'b0; end
        if (!f_act && fq.size() > 0 && int'($urandom_range(99)) >= gap_pct) f_act = 1'b1;
        if (!l_act && lq_a.size() > 0 && int'($urandom_range(99)) >= gap_pct) l_act = 1'b1;
        fetch_req = f_act;
        if (f_act) fetch_addr = fq[0];
        load_req = l_act;
        if (l_act) begin load_addr = lq_a[0]; load_data = lq_d[0]; end
      end
    end
  end

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(99) < 10) return 16'($urandom_range(65535, 64));
    return 16'($urandom_range(DEPTH - 1));
  endfunction

  task automatic push_load(input logic [15:0] a, input logic [15:0] d);
    lq_a.push_back(a);
    lq_d.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || lq_a.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(fq.size() + lq_a.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_sig_write(input int budget);
    int n;
    n = 0;
    while (mem_rw !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_write", 32'(mem_rw), 32'd1);
  endtask

  task automatic wait_sig_fgnt(input int budget);
    int n;
    n = 0;
    while (fetch_gnt !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fetch_gnt", 32'(fetch_gnt), 32'd1);
  endtask

  initial begin : main
    int lb;
    logic seen_f, first_load;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data", 32'(fetch_data), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_mem_rw", 32'(mem_rw), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);

    // single fetch of addr 5
    fq.push_back(16'd5);
    @(negedge clk); chk("t1_gnt_c1", 32'(fetch_gnt), 32'd0);
    @(negedge clk); chk("t1_gnt_c2", 32'(fetch_gnt), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd5);
    @(negedge clk); chk("t1_valid", 32'(fetch_valid), 32'd1);
    chk("t1_data", 32'(fetch_data), 32'hA3C1);
    chk("t1_err", 32'(fetch_err), 32'd0);
    wait_idle(20);

    // load burst 0..3
    for (int i = 0; i < 4; i++) push_load(16'(i), 16'h1000 + 16'(i));
    @(negedge clk); chk("t2_bubble", 32'(load_gnt), 32'd0);
    chk("t2_hold_bubble", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_gnt", 32'(load_gnt), 32'd1);
      chk("t2_rw", 32'(mem_rw), 32'd1);
      chk("t2_addr", 32'(mem_addr), 32'(i));
      chk("t2_hold", 32'(cpu_hold), 32'd1);
    end
    @(negedge clk); chk("t2_count", 32'(load_count), 32'd4);
    wait_idle(20);

    // simultaneous requests: load first, fetch after 8 (fair) or 20 (strict)
    for (int i = 0; i < 20; i++) push_load(16'(10 + i), 16'($urandom));
    fq.push_back(16'd12);
    lb = 0; seen_f = 1'b0; first_load = 1'b0;
    for (int c = 0; c < 60 && !seen_f; c++) begin
      @(negedge clk);
      if (load_gnt && lb == 0) first_load = 1'b1;
      if (load_gnt) lb++;
      if (fetch_gnt) seen_f = 1'b1;
    end
    chk("t3_load_first", 32'(first_load), 32'd1);
    chk("t3_fetch_seen", 32'(seen_f), 32'd1);
`ifdef IMEM_ARB_FAIR_EN
    chk("t3_loads_before_fetch", 32'(lb), 32'd8);
`else
    chk("t3_loads_before_fetch", 32'(lb), 32'd20);
`endif
    wait_idle(60);

    // out-of-range load and fetch
    push_load(16'd70, 16'h7777);
    @(negedge clk); chk("t4_bubble", 32'(load_gnt), 32'd0);
    @(negedge clk); chk("t4_gnt", 32'(load_gnt), 32'd1);
    chk("t4_rw", 32'(mem_rw), 32'd0);
    @(negedge clk); chk("t4_load_err", 32'(load_err), 32'd1);
    chk("t4_count", 32'(load_count), 32'd24);
    wait_idle(20);
    fq.push_back(16'd64);
    @(negedge clk);
    @(negedge clk); chk("t4_fgnt", 32'(fetch_gnt), 32'd1);
    @(negedge clk); chk("t4_fvalid", 32'(fetch_valid), 32'd1);
    chk("t4_fdata", 32'(fetch_data), 32'h0000);
    chk("t4_ferr", 32'(fetch_err), 32'd1);
    wait_idle(20);

    // randomized traffic
    gap_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (fq.size() < 3 && $urandom_range(99) < 20) fq.push_back(rand_addr());
      if (lq_a.size() < 4 && $urandom_range(99) < 25) push_load(rand_addr(), 16'($urandom));
    end
    gap_pct = 0;
    wait_idle(500);

    // saturation
    for (int i = 0; i < 130; i++) push_load(16'(i % DEPTH), 16'($urandom));
    wait_idle(400);
    chk("sat_count", 32'(load_count), 32'd127);

    // reset during a write cycle
    for (int i = 0; i < 10; i++) push_load(16'(i), 16'($urandom));
    wait_sig_write(20);
    #2 rst = 1'b1;
    lq_a.delete(); lq_d.delete();
    #1;
    chk("rst_mid_rw", 32'(mem_rw), 32'd0);
    chk("rst_mid_count", 32'(load_count), 32'd0);
    chk("rst_mid_valid", 32'(fetch_valid), 32'd0);
    chk("rst_mid_lerr", 32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(10);

    // reset right after a fetch grant: its fetch_valid must never appear
    fq.push_back(16'd3);
    wait_sig_fgnt(10);
    #1 rst = 1'b1;
    fq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("no_valid_after_rst", 32'(fetch_valid), 32'd0);
    end
    chk("rst_fetch_data2", 32'(fetch_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
